// File: rtl/jtframe_mc2_joydb9_if.sv
// Pin and result bundle for the Multicore 2 DB9 joystick reader.
// The slave side is the reader itself: it takes the raw pad pins and drives
// the shared select line plus the decoded joystick words. The master side is
// the board/frame logic that owns the pins and consumes the results.
interface jtframe_mc2_joydb9_if;
    logic        joy1_up_i;
    logic        joy1_down_i;
    logic        joy1_left_i;
    logic        joy1_right_i;
    logic        joy1_p6_i;
    logic        joy1_p9_i;
    logic        joy2_up_i;
    logic        joy2_down_i;
    logic        joy2_left_i;
    logic        joy2_right_i;
    logic        joy2_p6_i;
    logic        joy2_p9_i;
    logic        joyX_p7_o;
    logic [11:0] joy1;
    logic [11:0] joy2;
    logic        six1;
    logic        six2;
    logic        poll_done;

    modport slave (
        input  joy1_up_i, joy1_down_i, joy1_left_i, joy1_right_i, joy1_p6_i, joy1_p9_i,
        input  joy2_up_i, joy2_down_i, joy2_left_i, joy2_right_i, joy2_p6_i, joy2_p9_i,
        output joyX_p7_o, joy1, joy2, six1, six2, poll_done
    );

    modport master (
        output joy1_up_i, joy1_down_i, joy1_left_i, joy1_right_i, joy1_p6_i, joy1_p9_i,
        output joy2_up_i, joy2_down_i, joy2_left_i, joy2_right_i, joy2_p6_i, joy2_p9_i,
        input  joyX_p7_o, joy1, joy2, six1, six2, poll_done
    );
endinterface

// File: rtl/jtframe_mc2_joydb9.sv
// Multicore 2 DB9 joystick reader.
// Drives the Mega Drive select line through a fixed step sequence, samples
// both ports in parallel into shadow registers and commits complete polls
// only, so the frame logic never sees a half-read pad.
// Optional macro JTFRAME_MC2_6BTN_EN: when defined the full S0..S7 sequence
// runs and 6-button pads are decoded; when undefined the poll stops after S1
// and X/Y/Z/Mode read as released.
// Joystick words are active low: [0]R [1]L [2]D [3]U [4]B [5]C [6]A [7]X
// [8]Y [9]Z [10]Start [11]Mode.
module jtframe_mc2_joydb9 #(
    parameter int CLK_DIV     = 480,
    parameter int IDLE_STEPS  = 200,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    jtframe_mc2_joydb9_if.slave       pads
);

`ifdef JTFRAME_MC2_6BTN_EN
    localparam bit SIX_EN = 1'b1;
`else
    localparam bit SIX_EN = 1'b0;
`endif

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int IDLE_W = $clog2(IDLE_STEPS + 1);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_S0   = 4'd1,
        ST_S1   = 4'd2,
        ST_S2   = 4'd3,
        ST_S3   = 4'd4,
        ST_S4   = 4'd5,
        ST_S5   = 4'd6,
        ST_S6   = 4'd7,
        ST_S7   = 4'd8
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [DIV_W-1:0]    div_r;
    logic                tick_s;
    logic [IDLE_W-1:0]   idle_cnt_r;
    logic [IDLE_W-1:0]   idle_next_s;
    logic                sel_r;
    logic                sel_next_s;
    logic                commit_s;
    logic                smp0_s;
    logic                smp1_s;
    logic                smp5_s;
    logic                smp6_s;

    // Raw pins packed per port as {p9, p6, up, down, left, right}
    logic [11:0]         raw_s;
    logic [11:0]         sync_r [SYNC_STAGES];
    logic [5:0]          pin_s  [2];

    logic [11:0]         sh_r       [2];
    logic [11:0]         sh_next_s  [2];
    logic                pres_r     [2];
    logic                pres_next_s[2];
    logic                six_r      [2];
    logic                six_next_s [2];
    logic                six_eff_s  [2];
    logic [11:0]         fin_s      [2];

    logic [11:0]         joy1_r;
    logic [11:0]         joy2_r;
    logic                six1_r;
    logic                six2_r;
    logic                poll_done_r;

    assign raw_s = {pads.joy2_p9_i, pads.joy2_p6_i, pads.joy2_up_i, pads.joy2_down_i,
                    pads.joy2_left_i, pads.joy2_right_i,
                    pads.joy1_p9_i, pads.joy1_p6_i, pads.joy1_up_i, pads.joy1_down_i,
                    pads.joy1_left_i, pads.joy1_right_i};

    assign pin_s[0] = sync_r[SYNC_STAGES-1][5:0];
    assign pin_s[1] = sync_r[SYNC_STAGES-1][11:6];

    // Pin synchroniser chain, preset to "released" so reset never looks like a press
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= 12'hFFF;
            end
        end else begin
            sync_r[0] <= raw_s;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign tick_s = (div_r == DIV_W'(CLK_DIV - 1));

    // Step divider: one tick on the last cycle of every protocol step
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r <= DIV_W'(0);
        end else if (tick_s) begin
            div_r <= DIV_W'(0);
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // FSM state, idle step counter and registered select line
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idle_cnt_r <= IDLE_W'(0);
            sel_r      <= 1'b1;
        end else begin
            state_r    <= state_next_s;
            idle_cnt_r <= idle_next_s;
            sel_r      <= sel_next_s;
        end
    end

    // Step sequencing, sample strobes and commit; everything advances on the tick
    always_comb begin
        state_next_s = state_r;
        idle_next_s  = idle_cnt_r;
        commit_s     = 1'b0;
        smp0_s       = 1'b0;
        smp1_s       = 1'b0;
        smp5_s       = 1'b0;
        smp6_s       = 1'b0;
        if (tick_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (idle_cnt_r == IDLE_W'(IDLE_STEPS - 1)) begin
                        idle_next_s  = IDLE_W'(0);
                        state_next_s = ST_S0;
                    end else begin
                        idle_next_s  = idle_cnt_r + IDLE_W'(1);
                    end
                end
                ST_S0: begin
                    smp0_s       = 1'b1;
                    state_next_s = ST_S1;
                end
                ST_S1: begin
                    smp1_s       = 1'b1;
`ifdef JTFRAME_MC2_6BTN_EN
                    state_next_s = ST_S2;
`else
                    commit_s     = 1'b1;
                    state_next_s = ST_IDLE;
`endif
                end
                ST_S2:   state_next_s = ST_S3;
                ST_S3:   state_next_s = ST_S4;
                ST_S4:   state_next_s = ST_S5;
                ST_S5: begin
                    smp5_s       = 1'b1;
                    state_next_s = ST_S6;
                end
                ST_S6: begin
                    smp6_s       = 1'b1;
                    state_next_s = ST_S7;
                end
                ST_S7: begin
                    commit_s     = 1'b1;
                    state_next_s = ST_IDLE;
                end
                default: state_next_s = ST_IDLE;
            endcase
        end else begin
            state_next_s = state_r;
        end
        // Select follows the state being entered, so it moves the cycle after the tick
        case (state_next_s)
            ST_S1, ST_S3, ST_S5, ST_S7: sel_next_s = 1'b0;
            default:                    sel_next_s = 1'b1;
        endcase
    end

    // Shadow update per port and the masked word that a commit would publish
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            sh_next_s[p]   = sh_r[p];
            pres_next_s[p] = pres_r[p];
            six_next_s[p]  = six_r[p];
            if (smp0_s) begin
                // New poll: start from "all released" so stale buttons cannot leak in
                sh_next_s[p]      = 12'hFFF;
                sh_next_s[p][3:0] = pin_s[p][3:0];
                sh_next_s[p][4]   = pin_s[p][4];
                sh_next_s[p][5]   = pin_s[p][5];
                pres_next_s[p]    = 1'b0;
                six_next_s[p]     = 1'b0;
            end else if (smp1_s) begin
                sh_next_s[p][6]   = pin_s[p][4];
                sh_next_s[p][10]  = pin_s[p][5];
                pres_next_s[p]    = ~pin_s[p][1] & ~pin_s[p][0];
            end else if (smp5_s) begin
                six_next_s[p]     = (pin_s[p][3:0] == 4'b0000);
            end else if (smp6_s) begin
                if (six_r[p]) begin
                    sh_next_s[p][9]  = pin_s[p][3];
                    sh_next_s[p][8]  = pin_s[p][2];
                    sh_next_s[p][7]  = pin_s[p][1];
                    sh_next_s[p][11] = pin_s[p][0];
                end else begin
                    sh_next_s[p] = sh_r[p];
                end
            end else begin
                sh_next_s[p] = sh_r[p];
            end

            six_eff_s[p] = SIX_EN & six_next_s[p];
            fin_s[p]     = sh_next_s[p];
            if (!pres_next_s[p]) begin
                fin_s[p][6]  = 1'b1;
                fin_s[p][10] = 1'b1;
            end else begin
                fin_s[p][6]  = sh_next_s[p][6];
                fin_s[p][10] = sh_next_s[p][10];
            end
            if (!six_eff_s[p]) begin
                fin_s[p][7]  = 1'b1;
                fin_s[p][8]  = 1'b1;
                fin_s[p][9]  = 1'b1;
                fin_s[p][11] = 1'b1;
            end else begin
                fin_s[p][7]  = sh_next_s[p][7];
                fin_s[p][8]  = sh_next_s[p][8];
                fin_s[p][9]  = sh_next_s[p][9];
                fin_s[p][11] = sh_next_s[p][11];
            end
        end
    end

    // Shadow registers; a reset throws away any partially collected poll
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                sh_r[p]   <= 12'hFFF;
                pres_r[p] <= 1'b0;
                six_r[p]  <= 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                sh_r[p]   <= sh_next_s[p];
                pres_r[p] <= pres_next_s[p];
                six_r[p]  <= six_next_s[p];
            end
        end
    end

    // Published outputs change only on a commit, together with the poll_done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            joy1_r      <= 12'hFFF;
            joy2_r      <= 12'hFFF;
            six1_r      <= 1'b0;
            six2_r      <= 1'b0;
            poll_done_r <= 1'b0;
        end else begin
            poll_done_r <= commit_s;
            if (commit_s) begin
                joy1_r <= fin_s[0];
                joy2_r <= fin_s[1];
                six1_r <= six_eff_s[0];
                six2_r <= six_eff_s[1];
            end else begin
                joy1_r <= joy1_r;
                joy2_r <= joy2_r;
                six1_r <= six1_r;
                six2_r <= six2_r;
            end
        end
    end

    assign pads.joyX_p7_o = sel_r;
    assign pads.joy1      = joy1_r;
    assign pads.joy2      = joy2_r;
    assign pads.six1      = six1_r;
    assign pads.six2      = six2_r;
    assign pads.poll_done = poll_done_r;

endmodule

// File: tb/tb_jtframe_mc2_joydb9.sv
// Bench for jtframe_mc2_joydb9: behavioural pad models (Atari stick, 3-button
// and 6-button Mega Drive pads) on both ports, table of directed vectors plus
// hand-written sequences for reset timing, poll period and reset mid-poll.
`timescale 1ns/1ps
module tb_jtframe_mc2_joydb9;

    localparam int DIV  = 8;
    localparam int IDLE = 6;
`ifdef JTFRAME_MC2_6BTN_EN
    localparam int NSTEP = 8;
    localparam bit SIXB  = 1'b1;
`else
    localparam int NSTEP = 2;
    localparam bit SIXB  = 1'b0;
`endif
    localparam int PERIOD = (IDLE + NSTEP) * DIV;

    localparam logic [1:0] T_AT = 2'd0;
    localparam logic [1:0] T_3  = 2'd1;
    localparam logic [1:0] T_6  = 2'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    jtframe_mc2_joydb9_if pads();

    jtframe_mc2_joydb9 #(
        .CLK_DIV     (DIV),
        .IDLE_STEPS  (IDLE),
        .SYNC_STAGES (2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .pads (pads)
    );

    always #5 clk = ~clk;

    // ---------------- pad models ----------------
    logic [1:0]  typ1 = 2'd1;
    logic [1:0]  typ2 = 2'd1;
    logic [11:0] pr1  = 12'h000;   // pressed buttons, active high, joy bit layout
    logic [11:0] pr2  = 12'h000;
    logic        sel_q = 1'b1;
    logic [2:0]  fall_cnt = 3'd0;
    int          hi_len = 0;
    logic [5:0]  p1_s;
    logic [5:0]  p2_s;

    // Returns {p9, p6, up, down, left, right}, active low
    function automatic logic [5:0] pad_pins(input logic [1:0] typ, input logic [11:0] pr,
                                            input logic sel, input logic [2:0] cnt);
        logic u, d, l, r, p6, p9;
        u = ~pr[3]; d = ~pr[2]; l = ~pr[1]; r = ~pr[0]; p6 = ~pr[4]; p9 = ~pr[5];
        if (typ != T_AT) begin
            if (sel) begin
                if (typ == T_6 && cnt == 3'd3) begin
                    u = ~pr[9]; d = ~pr[8]; l = ~pr[7]; r = ~pr[11];
                end
            end else begin
                p6 = ~pr[6]; p9 = ~pr[10];
                if (typ == T_6 && cnt == 3'd3) begin
                    u = 1'b0; d = 1'b0; l = 1'b0; r = 1'b0;
                end else begin
                    l = 1'b0; r = 1'b0;
                end
            end
        end
        return {p9, p6, u, d, l, r};
    endfunction

    // Pad-internal counter: counts select falling edges, clears after a long high
    always @(posedge clk) begin
        sel_q <= pads.joyX_p7_o;
        if (sel_q && !pads.joyX_p7_o) fall_cnt <= fall_cnt + 3'd1;
        else if (hi_len >= 3 * DIV)   fall_cnt <= 3'd0;
        if (pads.joyX_p7_o) hi_len <= hi_len + 1;
        else                hi_len <= 0;
    end

    always_comb begin
        p1_s = pad_pins(typ1, pr1, pads.joyX_p7_o, fall_cnt);
        p2_s = pad_pins(typ2, pr2, pads.joyX_p7_o, fall_cnt);
    end

    assign pads.joy1_right_i = p1_s[0];
    assign pads.joy1_left_i  = p1_s[1];
    assign pads.joy1_down_i  = p1_s[2];
    assign pads.joy1_up_i    = p1_s[3];
    assign pads.joy1_p6_i    = p1_s[4];
    assign pads.joy1_p9_i    = p1_s[5];
    assign pads.joy2_right_i = p2_s[0];
    assign pads.joy2_left_i  = p2_s[1];
    assign pads.joy2_down_i  = p2_s[2];
    assign pads.joy2_up_i    = p2_s[3];
    assign pads.joy2_p6_i    = p2_s[4];
    assign pads.joy2_p9_i    = p2_s[5];

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_poll(input string name, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!pads.poll_done && cyc < 4 * PERIOD);
        if (!pads.poll_done) begin
            checks++;
            errors++;
            $display("FAIL %s: no poll_done within %0d cycles", name, cyc);
        end
    endtask

    typedef struct {
        logic [1:0]  t1;
        logic [11:0] pr1;
        logic [1:0]  t2;
        logic [11:0] pr2;
        logic [11:0] e1;
        logic [11:0] e2;
        logic        s1;
        logic        s2;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int cyc;

        // 3-button B+Start+Up / 6-button X+Mode
        vecs[0] = '{T_3,  12'h418, T_6,  12'h880, 12'hBE7, (SIXB ? 12'h77F : 12'hFFF), 1'b0, SIXB};
        // Atari Left+fire1 / 3-button A+C+Down+Right
        vecs[1] = '{T_AT, 12'h012, T_3,  12'h065, 12'hFED, 12'hF9A, 1'b0, 1'b0};
        // 6-button A+Y+Z+Start+Up / idle 3-button
        vecs[2] = '{T_6,  12'h748, T_3,  12'h000, (SIXB ? 12'h8B7 : 12'hBB7), 12'hFFF, SIXB, 1'b0};
        // idle 6-button / Atari Up+Right+fire2
        vecs[3] = '{T_6,  12'h000, T_AT, 12'h029, 12'hFFF, 12'hFD6, SIXB, 1'b0};
        // 3-button A+B+C+Start+Left / 6-button everything except Up/Right
        vecs[4] = '{T_3,  12'h472, T_6,  12'hFF6, 12'hB8D, (SIXB ? 12'h009 : 12'hB89), 1'b0, SIXB};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_joy1", {20'd0, pads.joy1}, 32'hFFF);
        chk("rst_joy2", {20'd0, pads.joy2}, 32'hFFF);
        chk("rst_sel", {31'd0, pads.joyX_p7_o}, 32'd1);
        chk("rst_six1", {31'd0, pads.six1}, 32'd0);
        chk("rst_six2", {31'd0, pads.six2}, 32'd0);
        chk("rst_poll_done", {31'd0, pads.poll_done}, 32'd0);
        rst = 1'b0;

        // First select falling edge after reset
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (pads.joyX_p7_o && cyc < 4 * PERIOD);
        chk("first_sel_fall", cyc, (IDLE + 1) * DIV);

        // Poll period between consecutive poll_done pulses
        wait_poll("poll_a", cyc);
        wait_poll("poll_b", cyc);
        chk("poll_period", cyc, PERIOD);

        // Table-driven vectors: one poll to flush, the next one is checked
        for (int i = 0; i < 5; i++) begin
            typ1 = vecs[i].t1; pr1 = vecs[i].pr1;
            typ2 = vecs[i].t2; pr2 = vecs[i].pr2;
            wait_poll("vec_flush", cyc);
            wait_poll("vec_poll", cyc);
            chk($sformatf("vec%0d_joy1", i), {20'd0, pads.joy1}, {20'd0, vecs[i].e1});
            chk($sformatf("vec%0d_joy2", i), {20'd0, pads.joy2}, {20'd0, vecs[i].e2});
            chk($sformatf("vec%0d_six1", i), {31'd0, pads.six1}, {31'd0, vecs[i].s1});
            chk($sformatf("vec%0d_six2", i), {31'd0, pads.six2}, {31'd0, vecs[i].s2});
        end

        // Reset in the middle of a poll (S4 with 6-button support, S1 without)
        typ1 = vecs[0].t1; pr1 = vecs[0].pr1;
        typ2 = vecs[0].t2; pr2 = vecs[0].pr2;
        wait_poll("mid_flush", cyc);
        wait_poll("mid_poll", cyc);
        chk("pre_rst_joy1", {20'd0, pads.joy1}, 32'hBE7);
        repeat ((IDLE + (SIXB ? 4 : 1)) * DIV + DIV / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_sel", {31'd0, pads.joyX_p7_o}, 32'd1);
        chk("midrst_joy1", {20'd0, pads.joy1}, 32'hFFF);
        chk("midrst_joy2", {20'd0, pads.joy2}, 32'hFFF);
        chk("midrst_poll_done", {31'd0, pads.poll_done}, 32'd0);
        rst = 1'b0;

        // Next poll must arrive exactly one full period later and be complete
        wait_poll("post_rst_poll", cyc);
        chk("post_rst_latency", cyc, PERIOD);
        chk("post_rst_joy1", {20'd0, pads.joy1}, {20'd0, vecs[0].e1});
        chk("post_rst_joy2", {20'd0, pads.joy2}, {20'd0, vecs[0].e2});
        chk("post_rst_six1", {31'd0, pads.six1}, {31'd0, vecs[0].s1});
        chk("post_rst_six2", {31'd0, pads.six2}, {31'd0, vecs[0].s2});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jtframe_mc2_joydb9.md
Name: jtframe_mc2_joydb9

Overview:
- Reads the two Multicore 2 DB9 ports and produces debounced, frame-coherent, active-low joystick words for the frame's joystick mapper.
- Drives the shared select line `joyX_p7_o` through the Sega Mega Drive multiplex protocol.
- Decodes 3-button pads, 6-button pads and plain Atari-style sticks.
- Sits between the board joystick pins and `jtframe_np1`'s joystick/coin/start logic, in the `clk_sys` domain.

Parameters:
- CLK_DIV, 480, clock cycles per protocol step (10 µs at 48 MHz); must be ≥ 4.
- IDLE_STEPS, 200, steps spent with select high between polls (pad counter reset, ≥ 1.5 ms).
- SYNC_STAGES, 2, flip-flop synchroniser depth on every pad input.

Ports:
- clk  in  1  system clock (`clk_sys`).
- rst  in  1  synchronous, active-high reset.
- joy1_up_i, joy1_down_i, joy1_left_i, joy1_right_i, joy1_p6_i, joy1_p9_i  in  1 each  port 1 raw pins, active low.
- joy2_up_i, joy2_down_i, joy2_left_i, joy2_right_i, joy2_p6_i, joy2_p9_i  in  1 each  port 2 raw pins, active low.
- joyX_p7_o  out  1  select line shared by both ports.
- joy1  out  12  port 1 state, active low: [0]R [1]L [2]D [3]U [4]B [5]C [6]A [7]X [8]Y [9]Z [10]Start [11]Mode.
- joy2  out  12  port 2 state, same layout as joy1.
- six1, six2  out  1 each  high when the port's last poll detected a 6-button pad.
- poll_done  out  1  one-cycle pulse when joy1/joy2 update.

Behaviour:
- **Reset values:** joyX_p7_o=1; joy1=joy2=12'hFFF; six1=six2=0; poll_done=0; all counters and step index 0; synchronisers preset to 1. Reset asserted mid-poll aborts the poll immediately and discards partial samples.
- **Step tick:** a divider counts 0..CLK_DIV-1 and emits a tick on the last count.
  - A step occupies exactly CLK_DIV cycles.
  - Pins are sampled on the tick cycle, i.e. at the end of the step, after CLK_DIV-1 cycles of settling.
  - Select changes on the cycle after the tick.
- **States:** IDLE, then S0..S7, then back to IDLE.
- **IDLE:** select=1 for IDLE_STEPS ticks, then go to S0.
- **Select level:** select=1 in S0, S2, S4, S6; select=0 in S1, S3, S5, S7.
- **Per-port samples**, held in shadow registers:
  - S0: U, D, L, R into [3:0]; p6 into B; p9 into C.
  - S1: p6 into A; p9 into Start. Pad-present flag = (L==0 && R==0).
  - S5: six-button flag = (U, D, L, R all 0).
  - S6: if the six-button flag is set, U into Z, D into Y, L into X, R into Mode.
  - S2, S3, S4, S7: no samples.
- **Pad not present:** A and Start are forced to 1. B and C keep their S0 values (Atari button 1 and button 2).
- **Six-button flag clear:** X, Y, Z and Mode are forced to 1.
- **Commit:** on the S7 tick, shadow registers are copied to joy1/joy2 and six1/six2, and poll_done pulses on that same cycle. Outputs never show a partial poll.
- **Poll period:** (8 + IDLE_STEPS) × CLK_DIV cycles, i.e. 208 × 480 = 99 840 cycles.
- **Counter wrap:** the divider and the step counter wrap cleanly; there is no free-running overflow.
- **Both ports:** decoded in parallel from the same select waveform; no arbitration.

Optional Feature:
- Macro: JTFRAME_MC2_6BTN_EN.
- **Defined:** full S0..S7 sequence as above.
- **Undefined:** the sequence is S0, S1, then IDLE; commit happens on the S1 tick. X, Y, Z and Mode are always 1 and six1/six2 are always 0. The poll period becomes (2 + IDLE_STEPS) × CLK_DIV.

Test Plan:
- **Reset:** hold rst 3 cycles, release. Required: joy1=joy2=12'hFFF, joyX_p7_o=1, first select falling edge at cycle IDLE_STEPS×CLK_DIV + CLK_DIV (+1 for registering).
- **3-button model on port 1:** press B and Start, stick up. Required after poll_done: joy1=12'hBE7 (bits 3, 4, 10 low), six1=0.
- **6-button model on port 2:** press X and Mode. Required after poll_done: joy2=12'h77F, six2=1. Six-button absence check: port 1 with a 3-button model gives six1=0 and joy1[11:7] high except A/Start as pressed.
- **Atari stick on port 1:** L/R never both low, p6 held low. Required: joy1[4]=0, joy1[6]=1, joy1[10]=1.
- **Reset mid-poll:** assert rst during S4. Required: joyX_p7_o=1 the next cycle, outputs 12'hFFF, no poll_done pulse. The next poll is complete and correct.
- **Macro undefined:** 6-button model with X pressed. Required: joy1[7]=1, six1=0, poll period 202×480 cycles between poll_done pulses.
